if_fetch_buf: RTL and testbench
===============================

# if_fetch_buf

Instruction-fetch buffer and IF/ID pipeline register, directly downstream of the PC stage. It takes `pc`/`rom_enable` and runs one-outstanding-request fetches on the SRAM-like instruction bus. It raises a stall request while a fetch is pending, holds returned instructions while ID is stalled, and discards in-flight responses on pipeline flush. It delivers `id_pc`/`id_inst`/`id_valid` to the decode stage.

## Interface
- `ADDR_W`, 32, instruction address width
- `DATA_W`, 32, instruction width
- `STALL_W`, 6, control stall bus width; bit 0 = PC, bit 1 = IF/ID, 1 = Stop
- `clk` in 1, sole clock, rising edge
- `reset` in 1, asynchronous, active-high
- `pc` in ADDR_W, current fetch address from PC stage
- `rom_enable` in 1, fetch allowed; low during start-up
- `stall` in STALL_W, control-module stall vector
- `flush` in 1, exception flush; PC loads `except_pc` on the same edge
- `inst_req` out 1, bus request
- `inst_addr` out ADDR_W, bus address
- `inst_addr_ok` in 1, request accepted this cycle
- `inst_data_ok` in 1, read data valid this cycle
- `inst_rdata` in DATA_W, read data
- `stallreq_if` out 1, fetch-not-complete stall request to control
- `id_pc` out ADDR_W, IF/ID pc
- `id_inst` out DATA_W, IF/ID instruction
- `id_valid` out 1, IF/ID holds a real instruction
- `id_adel` out 1, fetch address error (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, DROP. `req_pc` and `inst_buf` are internal registers.
- IDLE:
  - `inst_req = rom_enable & ~flush`; `inst_addr = pc`.
  - If `inst_req` is high: latch `pc` to `req_pc`. Go to WAIT if `inst_addr_ok`, else REQ.
- REQ:
  - `inst_req=1`; `inst_addr=req_pc`.
  - On `inst_addr_ok`: go to WAIT.
  - On `flush`: go to DROP if `inst_addr_ok` is high the same cycle, else IDLE (request withdrawn).
- WAIT: on `inst_data_ok`:
  - `flush` high: discard data, go to IDLE.
  - `stall[1]=0`: load IF/ID directly, go to IDLE.
  - Otherwise: `inst_buf <= inst_rdata`, go to HOLD.
- WAIT without `inst_data_ok`, `flush` high: go to DROP.
- HOLD:
  - `flush`: discard, go to IDLE.
  - `stall[1]=0`: load IF/ID from `inst_buf`/`req_pc`, go to IDLE.
- DROP: no request issued. Wait for `inst_data_ok`, discard the data, go to IDLE.
- `stallreq_if` = 1 in IDLE with `inst_req` high, in REQ, in DROP, and in WAIT unless `inst_data_ok` is high. It is 0 in HOLD, since control already keeps `stall[0]` high whenever `stall[1]` is high.
- IF/ID register, priority in this order:
  1. `flush`: clear to 0/0/0.
  2. `stall[1]=1`: hold.
  3. Fetch completes this cycle: load pc, inst, `valid=1`.
  4. Else: bubble (`id_inst=0`, `id_valid=0`, `id_pc` unchanged).
- Exactly one outstanding request at any time. The bus returns responses in order.

## Timing
- Reset: state IDLE; `id_pc`, `id_inst`, `id_valid`, `id_adel`, `req_pc`, `inst_buf` = 0. `inst_req=0` while `rom_enable=0`.
- Best case: `addr_ok` in cycle N, `data_ok` in N+1, IF/ID valid after the N+1 edge. This gives 1 instruction per 2 cycles.
- The bus never asserts `inst_data_ok` in the same cycle as the matching `inst_addr_ok`.
- `flush` and `inst_data_ok` in the same cycle: the data is dropped and no DROP state is entered.
- `flush` in IDLE: no request that cycle. The next cycle requests `except_pc`.
- Reset mid-fetch: FSM returns to IDLE immediately. The bus side is reset by the same `reset`.

## Configuration
- `IF_ADEL_CHECK_EN` defined:
  - In IDLE with `pc[1:0]!=0`: no bus request.
  - The fetch completes internally in the same cycle, with inst=0 and `id_adel=1` loaded under normal IF/ID rules.
  - `stallreq_if=0` for that cycle.
- Undefined: `pc[1:0]` is ignored and `id_adel` is tied 0.

## Structure
- Shared defines file:
  - FSM state encodings
  - `StallBus` width
  - `Stop`/`NoStop`
  - `ZeroWord`
  - `InstAddrBus`/`InstBus`
- One sub-module, `if_id_reg`: the IF/ID register with flush/stall/bubble priority. The FSM and bus interface stay in the top module.

## Test plan
- Reset release, `rom_enable` 0→1, `pc=0xbfc00000`, `addr_ok` the same cycle, `data_ok` next cycle with 0x24080001 -> `id_pc=0xbfc00000`, `id_inst=0x24080001`, `id_valid=1`. `stallreq_if` high exactly 1 cycle.
- `addr_ok` delayed 3 cycles -> `inst_req` and `inst_addr` held stable. `stallreq_if` high until the `data_ok` cycle.
- `data_ok` while `stall[1]=1` for 4 cycles -> FSM in HOLD, `id_*` unchanged. Loads the buffered inst on the first cycle with `stall[1]=0`.
- `flush` in WAIT, then `data_ok` 2 cycles later with 0xdeadbeef -> 0xdeadbeef never appears on `id_inst`. Next request `addr` = new `pc` (0xbfc00380).
- `flush` and `data_ok` in the same cycle -> data dropped, IDLE next cycle, `id_valid=0`.
- With `IF_ADEL_CHECK_EN` and `pc=0xbfc00002` -> no `inst_req`, `id_adel=1`, `id_inst=0`, `id_valid=1`.

Source files
------------

// File: rtl/if_fetch_buf_pkg.sv
// Shared definitions for the instruction-fetch buffer: bus widths, stall
// encodings and the fetch FSM state type.
package if_fetch_buf_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int StallBus    = 6;

  // Bit of the stall vector that freezes the IF/ID register
  localparam int StallIfId   = 1;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_buf_if_id_reg.sv
// IF/ID pipeline register: flush clears, stall holds, a completed fetch
// loads, otherwise a bubble is inserted with the pc left unchanged.
module if_id_reg
  import if_fetch_buf_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall_id,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [DATA_W-1:0] load_inst,
  input  logic              load_adel,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel
);

  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [DATA_W-1:0] inst_q,  inst_d;
  logic              valid_q, valid_d;
  logic              adel_q,  adel_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    adel_d  = adel_q;
    if (flush) begin
      pc_d    = '0;
      inst_d  = DATA_W'(ZeroWord);
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end else if (stall_id == Stop) begin
      // hold
    end else if (load) begin
      pc_d    = load_pc;
      inst_d  = load_inst;
      valid_d = 1'b1;
      adel_d  = load_adel;
    end else begin
      inst_d  = DATA_W'(ZeroWord);
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
    end
  end

  assign id_pc    = pc_q;
  assign id_inst  = inst_q;
  assign id_valid = valid_q;
  assign id_adel  = adel_q;

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch buffer: one-outstanding-request fetch FSM on the SRAM-like
// instruction bus feeding the IF/ID register. Optional macro IF_ADEL_CHECK_EN.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter int ADDR_W  = InstAddrBus,
  parameter int DATA_W  = InstBus,
  parameter int STALL_W = StallBus
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               rom_enable,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  output logic               inst_req,
  output logic [ADDR_W-1:0]  inst_addr,
  input  logic               inst_addr_ok,
  input  logic               inst_data_ok,
  input  logic [DATA_W-1:0]  inst_rdata,
  output logic               stallreq_if,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [DATA_W-1:0]  id_inst,
  output logic               id_valid,
  output logic               id_adel
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [DATA_W-1:0] inst_buf_q, inst_buf_d;

  logic              done;
  logic [ADDR_W-1:0] done_pc;
  logic [DATA_W-1:0] done_inst;
  logic              done_adel;
  logic              misaligned;
  logic              stall_id;
  logic              unused_stall;

  assign stall_id     = stall[StallIfId];
  assign unused_stall = ^{stall[STALL_W-1:StallIfId+1], stall[0]};

`ifdef IF_ADEL_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    inst_buf_d  = inst_buf_q;
    inst_req    = 1'b0;
    inst_addr   = req_pc_q;
    stallreq_if = NoStop;
    done        = 1'b0;
    done_pc     = req_pc_q;
    done_inst   = DATA_W'(ZeroWord);
    done_adel   = 1'b0;
    case (state_q)
      S_IDLE: begin
        inst_addr = pc;
        if (rom_enable && !flush) begin
          if (misaligned) begin
            // Address error completes without touching the bus
            done      = 1'b1;
            done_pc   = pc;
            done_adel = 1'b1;
          end else begin
            inst_req    = 1'b1;
            stallreq_if = Stop;
            req_pc_d    = pc;
            state_d     = inst_addr_ok ? S_WAIT : S_REQ;
          end
        end
      end
      S_REQ: begin
        inst_req    = 1'b1;
        stallreq_if = Stop;
        if (flush)             state_d = inst_addr_ok ? S_DROP : S_IDLE;
        else if (inst_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (flush) begin
            state_d = S_IDLE;
          end else if (stall_id == NoStop) begin
            done      = 1'b1;
            done_inst = inst_rdata;
            state_d   = S_IDLE;
          end else begin
            inst_buf_d = inst_rdata;
            state_d    = S_HOLD;
          end
        end else begin
          stallreq_if = Stop;
          if (flush) state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (stall_id == NoStop) begin
          done      = 1'b1;
          done_inst = inst_buf_q;
          state_d   = S_IDLE;
        end
      end
      S_DROP: begin
        stallreq_if = Stop;
        if (inst_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_pc_q   <= '0;
      inst_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall_id  (stall_id),
    .load      (done),
    .load_pc   (done_pc),
    .load_inst (done_inst),
    .load_adel (done_adel),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_valid  (id_valid),
    .id_adel   (id_adel)
  );

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: directed scenarios plus randomized bus/stall/flush
// traffic compared every cycle against a transaction-level fetch model.
module tb_if_fetch_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        rom_enable;
  logic [5:0]  stall;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  if_fetch_buf dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .rom_enable   (rom_enable),
    .stall        (stall),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .stallreq_if  (stallreq_if),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .id_adel      (id_adel)
  );

  always #5 clk = ~clk;

`ifdef IF_ADEL_CHECK_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Fetch transaction model: one fetch in flight, tracked as flags
  bit          m_busy, m_acc, m_kill, m_have;
  logic [31:0] m_pc, m_buf;
  logic [31:0] e_pc, e_inst;
  bit          e_valid, e_adel;

  // Bus slave for random traffic
  bit          auto_bus;
  bit          sl_out;
  int          sl_cnt;
  logic [31:0] sl_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic set_in(input bit rom, input logic [31:0] pcv, input bit aok, input bit dok,
                        input logic [31:0] rd, input logic [5:0] st, input bit fl);
    rom_enable = rom; pc = pcv; inst_addr_ok = aok; inst_data_ok = dok;
    inst_rdata = rd; stall = st; flush = fl;
    #1;
  endtask

  task automatic model_clear();
    m_busy = 0; m_acc = 0; m_kill = 0; m_have = 0; m_pc = '0; m_buf = '0;
    e_pc = '0; e_inst = '0; e_valid = 0; e_adel = 0;
    sl_out = 0; sl_cnt = 0; sl_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rom_enable = 0; pc = '0; stall = '0; flush = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    #1;
  endtask

  // Compare at the falling edge, then advance the model across the rising edge
  task automatic step();
    bit          e_req, e_stall, misal, done, dadel;
    logic [31:0] e_addr, dpc, dinst;
    @(negedge clk);
    misal = ADEL && (pc[1:0] != 2'b00);
    if (!m_busy) begin
      e_req = rom_enable && !flush && !misal; e_stall = e_req; e_addr = pc;
    end else if (!m_acc) begin
      e_req = 1; e_stall = 1; e_addr = m_pc;
    end else begin
      e_req = 0; e_addr = m_pc;
      e_stall = m_kill ? 1'b1 : (m_have ? 1'b0 : !inst_data_ok);
    end
    chk("inst_req", inst_req, e_req);
    if (e_req) chk("inst_addr", inst_addr, e_addr);
    chk("stallreq_if", stallreq_if, e_stall);
    chk("id_pc", id_pc, e_pc);
    chk("id_inst", id_inst, e_inst);
    chk("id_valid", id_valid, e_valid);
    chk("id_adel", id_adel, e_adel);

    done = 0; dpc = '0; dinst = '0; dadel = 0;
    if (!m_busy) begin
      if (rom_enable && !flush) begin
        if (misal) begin
          done = 1; dpc = pc; dadel = 1;
        end else begin
          m_busy = 1; m_pc = pc; m_acc = inst_addr_ok; m_kill = 0; m_have = 0;
        end
      end
    end else if (!m_acc) begin
      if (flush) begin
        if (inst_addr_ok) begin m_acc = 1; m_kill = 1; end
        else m_busy = 0;
      end else if (inst_addr_ok) m_acc = 1;
    end else if (m_kill) begin
      if (inst_data_ok) m_busy = 0;
    end else if (!m_have) begin
      if (inst_data_ok) begin
        if (flush) m_busy = 0;
        else if (!stall[1]) begin done = 1; dpc = m_pc; dinst = inst_rdata; m_busy = 0; end
        else begin m_have = 1; m_buf = inst_rdata; end
      end else if (flush) m_kill = 1;
    end else begin
      if (flush) m_busy = 0;
      else if (!stall[1]) begin done = 1; dpc = m_pc; dinst = m_buf; m_busy = 0; end
    end

    if (flush) begin
      e_pc = '0; e_inst = '0; e_valid = 0; e_adel = 0;
    end else if (stall[1]) begin
      // held
    end else if (done) begin
      e_pc = dpc; e_inst = dinst; e_valid = 1; e_adel = dadel;
    end else begin
      e_inst = '0; e_valid = 0; e_adel = 0;
    end

    if (auto_bus) begin
      if (inst_data_ok) sl_out = 0;
      else if (sl_out && sl_cnt != 0) sl_cnt--;
      if (inst_req && inst_addr_ok) begin
        sl_out = 1; sl_cnt = $urandom_range(0, 2); sl_data = $urandom;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    bit          s1;
    auto_bus = 0;
    model_clear();
    do_reset();
    chk("rst id_pc", id_pc, 32'h0);
    chk("rst id_inst", id_inst, 32'h0);
    chk("rst id_valid", id_valid, 0);
    chk("rst id_adel", id_adel, 0);
    chk("rst inst_req", inst_req, 0);

    // Best-case fetch
    set_in(1, 32'hbfc00000, 1, 0, 32'h0, 6'h0, 0);
    chk("t1 req", inst_req, 1);
    chk("t1 addr", inst_addr, 32'hbfc00000);
    chk("t1 stallreq", stallreq_if, 1);
    step();
    set_in(0, 32'hbfc00004, 0, 1, 32'h24080001, 6'h0, 0);
    chk("t1 stallreq data cycle", stallreq_if, 0);
    step();
    chk("t1 id_pc", id_pc, 32'hbfc00000);
    chk("t1 id_inst", id_inst, 32'h24080001);
    chk("t1 id_valid", id_valid, 1);

    // Address phase stretched by three cycles
    set_in(1, 32'hbfc00004, 0, 0, 32'h0, 6'h0, 0);
    step();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 32'hbfc00100, 0, 0, 32'h0, 6'h0, 0);
      chk("t2 req held", inst_req, 1);
      chk("t2 addr held", inst_addr, 32'hbfc00004);
      step();
    end
    set_in(1, 32'hbfc00100, 1, 0, 32'h0, 6'h0, 0);
    chk("t2 addr accept", inst_addr, 32'hbfc00004);
    step();
    set_in(0, 32'hbfc00100, 0, 1, 32'h8c090010, 6'h0, 0);
    step();
    chk("t2 id_pc", id_pc, 32'hbfc00004);
    chk("t2 id_inst", id_inst, 32'h8c090010);

    // Data arrives while ID is stalled for four cycles
    set_in(1, 32'hbfc00008, 1, 0, 32'h0, 6'h0, 0);
    step();
    set_in(0, 32'hbfc00008, 0, 1, 32'h11111111, 6'h03, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 32'hbfc00008, 0, 0, 32'h0, 6'h03, 0);
      chk("t3 hold stallreq", stallreq_if, 0);
      chk("t3 hold id_inst", id_inst, 32'h0);
      chk("t3 hold id_pc", id_pc, 32'hbfc00004);
      step();
    end
    set_in(0, 32'hbfc00008, 0, 0, 32'h0, 6'h00, 0);
    step();
    chk("t3 id_pc", id_pc, 32'hbfc00008);
    chk("t3 id_inst", id_inst, 32'h11111111);
    chk("t3 id_valid", id_valid, 1);

    // Flush while waiting for data; stale response arrives later
    set_in(1, 32'hbfc00200, 1, 0, 32'h0, 6'h0, 0);
    step();
    set_in(1, 32'hbfc00380, 0, 0, 32'h0, 6'h0, 1);
    step();
    set_in(1, 32'hbfc00380, 0, 0, 32'h0, 6'h0, 0);
    chk("t4 drop no req", inst_req, 0);
    step();
    set_in(1, 32'hbfc00380, 0, 1, 32'hdeadbeef, 6'h0, 0);
    chk("t4 drop no req 2", inst_req, 0);
    step();
    chk("t4 stale not loaded", id_inst, 32'h0);
    chk("t4 id_valid", id_valid, 0);
    set_in(1, 32'hbfc00380, 1, 0, 32'h0, 6'h0, 0);
    chk("t4 new req", inst_req, 1);
    chk("t4 new addr", inst_addr, 32'hbfc00380);
    step();
    set_in(0, 32'hbfc00384, 0, 1, 32'h3c1d8000, 6'h0, 0);
    step();
    chk("t4 id_pc", id_pc, 32'hbfc00380);
    chk("t4 id_inst", id_inst, 32'h3c1d8000);

    // Flush coincident with data
    set_in(1, 32'hbfc00384, 1, 0, 32'h0, 6'h0, 0);
    step();
    set_in(0, 32'hbfc00384, 0, 1, 32'hcafef00d, 6'h0, 1);
    step();
    chk("t5 id_valid", id_valid, 0);
    chk("t5 id_inst", id_inst, 32'h0);
    set_in(0, 32'hbfc00388, 0, 0, 32'h0, 6'h0, 0);
    chk("t5 idle stallreq", stallreq_if, 0);
    step();
    set_in(1, 32'hbfc00388, 0, 0, 32'h0, 6'h0, 0);
    chk("t5 idle req", inst_req, 1);
    step();
    do_reset();

`ifdef IF_ADEL_CHECK_EN
    set_in(1, 32'hbfc00002, 0, 0, 32'h0, 6'h0, 0);
    chk("t6 no req", inst_req, 0);
    chk("t6 stallreq", stallreq_if, 0);
    step();
    chk("t6 id_adel", id_adel, 1);
    chk("t6 id_inst", id_inst, 32'h0);
    chk("t6 id_valid", id_valid, 1);
    chk("t6 id_pc", id_pc, 32'hbfc00002);
    set_in(0, 32'h0, 0, 0, 32'h0, 6'h0, 0);
    step();
    do_reset();
`endif

    // Randomized traffic with a reset in the middle
    auto_bus = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      rpc = $urandom;
      rpc[1:0] = (ADEL && ($urandom % 8 == 0)) ? 2'b10 : 2'b00;
      s1 = ($urandom % 4) == 0;
      set_in(($urandom % 10) != 0, rpc, $urandom % 2, sl_out && sl_cnt == 0,
             (sl_out && sl_cnt == 0) ? sl_data : $urandom,
             {4'b0, s1, s1 | 1'($urandom % 2)}, ($urandom % 16) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
